// File: rtl/move_arbiter_pipe.sv
// Best-move arbiter: a masked, optionally pipelined max-tree over N_SQ candidate
// words, followed by a drain FSM that offers each winner on valid/ready and pops
// the winner's source stack until every source reports empty.
module move_arbiter_pipe #(
   parameter int unsigned N_SQ      = 64,
   parameter int unsigned MOVE_W    = 16,
   parameter int unsigned REG_EVERY = 2,
   parameter int unsigned SQ_LAT    = 1,
   parameter int unsigned SWAP_SRC  = 1,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [N_SQ*MOVE_W-1:0] cand,
   input  logic [N_SQ-1:0]        cand_empty,
   output logic [N_SQ-1:0]        stack_read,
   output logic [MOVE_W-1:0]      best_move,
   output logic                   best_valid,
   input  logic                   best_ready,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       move_count,
   output logic                   err
);
   localparam int unsigned IDX_W     = $clog2(N_SQ);
   localparam int unsigned LEVELS    = $clog2(N_SQ);
   localparam int unsigned RE_DIV    = (REG_EVERY == 0) ? 1 : REG_EVERY;
   localparam int unsigned TREE_L    = (REG_EVERY == 0) ? 0 : (LEVELS + RE_DIV - 1) / RE_DIV;
   localparam int unsigned WAIT_N    = TREE_L + SQ_LAT;
   localparam int unsigned WAIT_LAST = (WAIT_N == 0) ? 0 : WAIT_N - 1;
   localparam int unsigned WAIT_W    = $clog2(WAIT_N + 2);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_EVAL, S_OFFER, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [IDX_W-1:0]    src_q, src_d;
   logic [N_SQ-1:0]     stack_read_q, stack_read_d;
   logic [MOVE_W-1:0]   best_move_q, best_move_d;
   logic                best_valid_q, best_valid_d;
   logic [CNT_W-1:0]    move_count_q, move_count_d;
   logic                err_q, err_d;
   logic [MOVE_W-1:0]   tree_out;
   logic [6:0]          src_dec;

   // Level 0 holds the masked candidates; level l holds N_SQ>>l partial maxima.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned NN = N_SQ >> l;
      logic [NN*MOVE_W-1:0] node_o;

      if (l == 0) begin : g_leaf
         // Empty sources contribute 0 so they can never win.
         always_comb begin
            node_o = '0;
            for (int unsigned k = 0; k < N_SQ; k++) begin
               node_o[k*MOVE_W +: MOVE_W] = cand_empty[k] ? '0 : cand[k*MOVE_W +: MOVE_W];
            end
         end
      end else begin : g_cmp
         logic [NN*MOVE_W-1:0] node_d;

         // Pairwise unsigned max; the lower-index side keeps a tie.
         always_comb begin
            node_d = '0;
            for (int unsigned k = 0; k < NN; k++) begin
               if (g_lvl[l-1].node_o[(2*k+1)*MOVE_W +: MOVE_W] > g_lvl[l-1].node_o[2*k*MOVE_W +: MOVE_W])
                  node_d[k*MOVE_W +: MOVE_W] = g_lvl[l-1].node_o[(2*k+1)*MOVE_W +: MOVE_W];
               else
                  node_d[k*MOVE_W +: MOVE_W] = g_lvl[l-1].node_o[2*k*MOVE_W +: MOVE_W];
            end
         end

         if ((REG_EVERY != 0) && ((l % RE_DIV == 0) || (l == LEVELS))) begin : g_reg
            logic [NN*MOVE_W-1:0] node_q;
            // Pipeline cut after every REG_EVERY levels and at the root.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) node_q <= '0;
               else     node_q <= node_d;
            end
            assign node_o = node_q;
         end else begin : g_comb
            assign node_o = node_d;
         end
      end
   end

   assign tree_out = g_lvl[LEVELS].node_o;

   // Source square carried in the move word; kept one bit wider for the range check.
   always_comb begin
      if (SWAP_SRC != 0) src_dec = 7'({tree_out[2:0], tree_out[5:3]});
      else               src_dec = 7'(tree_out[IDX_W-1:0]);
   end

   // Drain FSM next-state and datapath updates.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      src_d        = src_q;
      stack_read_d = '0;
      best_move_d  = best_move_q;
      best_valid_d = best_valid_q;
      move_count_d = move_count_q;
      err_d        = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_SETTLE;
               wait_d       = '0;
               move_count_d = '0;
            end
         end
         S_SETTLE: begin
            if (wait_q >= WAIT_W'(WAIT_LAST)) state_d = S_EVAL;
            else                              wait_d  = wait_q + 1'b1;
         end
         S_EVAL: begin
            if (tree_out == '0) begin
               state_d = S_DONE;
            end else if ((src_dec >= 7'(N_SQ)) || cand_empty[src_dec[IDX_W-1:0]]) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               best_move_d  = tree_out;
               best_valid_d = 1'b1;
               src_d        = src_dec[IDX_W-1:0];
               state_d      = S_OFFER;
            end
         end
         S_OFFER: begin
            if (best_ready) begin
               best_valid_d         = 1'b0;
               stack_read_d[src_q]  = 1'b1;
               if (move_count_q != '1) move_count_d = move_count_q + 1'b1;
               wait_d               = '0;
               state_d              = S_SETTLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any pass and drops a pending pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wait_q       <= '0;
         src_q        <= '0;
         stack_read_q <= '0;
         best_move_q  <= '0;
         best_valid_q <= 1'b0;
         move_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         src_q        <= src_d;
         stack_read_q <= stack_read_d;
         best_move_q  <= best_move_d;
         best_valid_q <= best_valid_d;
         move_count_q <= move_count_d;
         err_q        <= err_d;
      end
   end

   assign stack_read = stack_read_q;
   assign best_move  = best_move_q;
   assign best_valid = best_valid_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign move_count = move_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_move_arbiter_pipe.sv
// Bench for move_arbiter_pipe: table of single-pass scenarios, hand-written
// backpressure / reset / sticky-error sequences, and randomized drain passes
// compared against a stack-merge reference model.
`timescale 1ns/1ps
module tb_move_arbiter_pipe;
   localparam int unsigned N_SQ      = 64;
   localparam int unsigned MOVE_W    = 16;
   localparam int unsigned REG_EVERY = 2;
   localparam int unsigned SQ_LAT    = 1;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned LEVELS    = 6;
   localparam int unsigned TREE_L    = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam int unsigned W_SETTLE  = TREE_L + SQ_LAT;
   localparam int unsigned DEPTH     = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [N_SQ*MOVE_W-1:0] cand;
   logic [N_SQ-1:0]        cand_empty;
   logic [N_SQ-1:0]        stack_read;
   logic [MOVE_W-1:0]      best_move;
   logic                   best_valid;
   logic                   best_ready;
   logic                   busy;
   logic                   done;
   logic [CNT_W-1:0]       move_count;
   logic                   err;

   always #5 clk = ~clk;

   move_arbiter_pipe #(
      .N_SQ(N_SQ), .MOVE_W(MOVE_W), .REG_EVERY(REG_EVERY),
      .SQ_LAT(SQ_LAT), .SWAP_SRC(1), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cand(cand), .cand_empty(cand_empty),
      .stack_read(stack_read), .best_move(best_move), .best_valid(best_valid),
      .best_ready(best_ready), .busy(busy), .done(done), .move_count(move_count),
      .err(err)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] stk [N_SQ][DEPTH];
   int unsigned depth [N_SQ];
   logic [15:0] got[$];
   logic [15:0] exp_q[$];
   bit          exp_err;
   bit          rand_ready;
   bit          saw_done;
   int unsigned done_cyc;
   logic [7:0]  cnt_at_done;

   typedef struct {
      int          n;
      int          sq0;
      logic [15:0] mv0;
      int          sq1;
      logic [15:0] mv1;
      logic [15:0] exp_first;
      int          exp_count;
      bit          exp_err;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] swap6(input logic [5:0] v);
      return {v[2:0], v[5:3]};
   endfunction

   // Present each square's top; empty squares carry junk that must be ignored.
   task automatic drive_cand();
      for (int k = 0; k < N_SQ; k++) begin
         cand_empty[k] = (depth[k] == 0);
         cand[k*MOVE_W +: MOVE_W] = (depth[k] != 0) ? stk[k][depth[k]-1] : 16'($urandom);
      end
   endtask

   task automatic clear_stacks();
      for (int k = 0; k < N_SQ; k++) depth[k] = 0;
   endtask

   task automatic push(input int k, input logic [15:0] mv);
      stk[k][depth[k]] = mv;
      depth[k]++;
   endtask

   // One clock: record handshakes, verify pops and stall hold, model square pops.
   task automatic step();
      bit          hs;
      bit          stall;
      logic [15:0] mv_prev;
      logic [63:0] sr_exp;
      hs      = (best_valid === 1'b1) && (best_ready === 1'b1);
      stall   = (best_valid === 1'b1) && (best_ready === 1'b0);
      mv_prev = best_move;
      @(posedge clk);
      #1;
      sr_exp = '0;
      if (hs) begin
         got.push_back(mv_prev);
         sr_exp[swap6(mv_prev[5:0])] = 1'b1;
      end
      if (hs || (stack_read != '0)) check("stack_read", stack_read, sr_exp);
      if (stall) check("stall_hold", {best_valid, best_move}, {1'b1, mv_prev});
      for (int k = 0; k < N_SQ; k++)
         if ((stack_read[k] === 1'b1) && (depth[k] != 0)) depth[k]--;
      drive_cand();
      if (rand_ready) best_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1; start = 1'b0; best_ready = 1'b0; rand_ready = 1'b0;
      clear_stacks(); drive_cand();
      step(); step();
      check("reset_stack_read", stack_read, 64'h0);
      check("reset_outputs", {best_move, best_valid, busy, done, move_count, err}, 64'h0);
      rst = 1'b0;
      step();
   endtask

   task automatic wait_done(input int unsigned budget);
      saw_done = 1'b0; done_cyc = 0; cnt_at_done = '0;
      for (int unsigned c = 1; (c <= budget) && !saw_done; c++) begin
         step();
         if (done === 1'b1) begin
            saw_done = 1'b1; done_cyc = c; cnt_at_done = move_count;
         end
      end
      check("pass_done_seen", 64'(saw_done), 64'h1);
      if (saw_done) begin
         step();
         check("idle_after_done", {busy, done}, 64'h0);
      end
   endtask

   task automatic run_pass(input int unsigned budget);
      got.delete();
      start = 1'b1; step(); start = 1'b0;
      wait_done(budget);
   endtask

   // Reference: repeatedly take the largest top, pop the square named in the word.
   task automatic model();
      int unsigned d [N_SQ];
      int          best_k;
      logic [15:0] best;
      logic [5:0]  s;
      exp_q.delete(); exp_err = 1'b0;
      d = depth;
      while (1) begin
         best = '0; best_k = -1;
         for (int k = 0; k < N_SQ; k++)
            if ((d[k] != 0) && (stk[k][d[k]-1] > best)) begin
               best = stk[k][d[k]-1]; best_k = k;
            end
         if (best_k < 0) break;
         s = swap6(best[5:0]);
         if (d[s] == 0) begin exp_err = 1'b1; break; end
         exp_q.push_back(best);
         d[s]--;
      end
   endtask

   task automatic compare_model(input string tag);
      int unsigned n;
      check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int unsigned i = 0; i < n; i++) check({tag, "_move"}, 64'(got[i]), 64'(exp_q[i]));
      check({tag, "_count"}, 64'(cnt_at_done), 64'((exp_q.size() > 255) ? 255 : exp_q.size()));
      check({tag, "_err"}, 64'(err), 64'(exp_err));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1; start = 1'b0; best_ready = 1'b0; rand_ready = 1'b0;
      clear_stacks(); drive_cand();

      tbl[0] = '{0, 0,  16'h0000, 0,  16'h0000, 16'h0000, 0, 1'b0}; // all empty
      tbl[1] = '{1, 9,  16'h0A49, 0,  16'h0000, 16'h0A49, 1, 1'b0}; // single move, src 9
      tbl[2] = '{2, 3,  16'h5018, 40, 16'h5018, 16'h5018, 1, 1'b1}; // tie; second decodes to popped sq 3
      tbl[3] = '{1, 5,  16'h003F, 0,  16'h0000, 16'h0000, 0, 1'b1}; // names empty square 63
      tbl[4] = '{2, 12, 16'h7021, 50, 16'h8016, 16'h8016, 2, 1'b0}; // two distinct moves
      tbl[5] = '{2, 0,  16'h0040, 63, 16'hFFFF, 16'hFFFF, 2, 1'b0}; // index and value extremes

      for (int i = 0; i < 6; i++) begin
         apply_reset();
         if (tbl[i].n > 0) push(tbl[i].sq0, tbl[i].mv0);
         if (tbl[i].n > 1) push(tbl[i].sq1, tbl[i].mv1);
         drive_cand();
         best_ready = 1'b1;
         run_pass(200);
         check($sformatf("tbl%0d_first", i), 64'((got.size() > 0) ? got[0] : 16'h0), 64'(tbl[i].exp_first));
         check($sformatf("tbl%0d_len", i), 64'(got.size()), 64'(tbl[i].exp_count));
         check($sformatf("tbl%0d_count", i), 64'(cnt_at_done), 64'(tbl[i].exp_count));
         check($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
         check($sformatf("tbl%0d_done_cyc", i), 64'(done_cyc),
               64'(W_SETTLE + tbl[i].exp_count * (W_SETTLE + 2) + 1));
      end

      // Backpressure with a start pulse that must be ignored while busy.
      apply_reset();
      push(9, 16'h0A49); drive_cand();
      got.delete();
      start = 1'b1; step(); start = 1'b0;
      seen = 1'b0;
      for (int c = 0; (c < 20) && !seen; c++) begin
         step();
         if (best_valid === 1'b1) seen = 1'b1;
      end
      check("bp_valid_seen", 64'(seen), 64'h1);
      for (int c = 0; c < 7; c++) begin
         start = (c == 3);
         step();
         check("bp_hold", {stack_read, best_valid, best_move}, {64'h0, 1'b1, 16'h0A49});
      end
      start = 1'b0;
      best_ready = 1'b1;
      wait_done(100);
      check("bp_len", 64'(got.size()), 64'h1);
      check("bp_count", 64'(cnt_at_done), 64'h1);

      // Asynchronous reset while a move is on offer, then a clean pass.
      apply_reset();
      push(9, 16'h0A49); drive_cand();
      start = 1'b1; step(); start = 1'b0;
      seen = 1'b0;
      for (int c = 0; (c < 20) && !seen; c++) begin
         step();
         if (best_valid === 1'b1) seen = 1'b1;
      end
      check("rst_offer_seen", 64'(seen), 64'h1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_stack_read", stack_read, 64'h0);
      check("rst_mid_outputs", {best_move, best_valid, busy, done, move_count, err}, 64'h0);
      #1 rst = 1'b0;
      best_ready = 1'b1;
      run_pass(200);
      check("rst_clean_len", 64'(got.size()), 64'h1);
      check("rst_clean_move", 64'((got.size() > 0) ? got[0] : 16'h0), 64'h0A49);
      check("rst_clean_count", 64'(cnt_at_done), 64'h1);
      check("rst_clean_err", 64'(err), 64'h0);

      // err survives a later good pass; only reset clears it.
      apply_reset();
      push(5, 16'h003F); drive_cand();
      best_ready = 1'b1;
      run_pass(200);
      check("sticky_set", 64'(err), 64'h1);
      clear_stacks(); push(9, 16'h0A49); drive_cand();
      run_pass(200);
      check("sticky_kept", 64'(err), 64'h1);
      check("sticky_count", 64'(cnt_at_done), 64'h1);

      // Randomized drain passes with random downstream stalls.
      apply_reset();
      for (int p = 0; p < 5; p++) begin
         clear_stacks();
         for (int k = 0; k < N_SQ; k++)
            if ($urandom_range(0, 3) == 0)
               for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                  push(k, {10'($urandom_range(1, 1023)), swap6(6'(k))});
         drive_cand();
         model();
         rand_ready = 1'b1;
         run_pass(4000);
         rand_ready = 1'b0;
         compare_model("rand");
      end

      // 256 moves: move_count must stop at all-ones.
      clear_stacks();
      for (int k = 0; k < N_SQ; k++)
         for (int j = 0; j < int'(DEPTH); j++)
            push(k, {10'($urandom_range(1, 1023)), swap6(6'(k))});
      drive_cand();
      model();
      best_ready = 1'b1;
      run_pass(5000);
      compare_model("sat");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
